video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
- Synthesizable, parametrised raster timing and test-pattern source driving the line-buffer path (line_buf_ctrl_top and successors).
- Produces vsync/hsync/de plus NCH pixel channels of DW bits, with programmable polarity and porches.
- Sends N frames or runs continuously, with a graceful stop.
- Same port style as the line-buffer input, so benches and FPGA bring-up share one stimulus source.

Parameters:
- DW, 10, bits per colour channel
- NCH, 3, number of colour channels
- VSYNC_POL, 0, 0 active-high, 1 active-low
- HSYNC_POL, 0, 0 active-high, 1 active-low
- VSW / VBP / VACT / VFP, 1 / 1 / 4 / 1, vertical sync / back porch / active / front porch, in lines
- HSW / HBP / HACT / HFP, 1 / 2 / 10 / 2, horizontal sync / back porch / active / front porch, in clocks
- FCW, 16, frame-count width

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  single-cycle start request; accepted only in IDLE
- i_nframes  in  FCW  frames to send; 0 = continuous
- i_stop  in  1  request stop at end of current frame
- i_mode  in  2  pattern: 0 ramp, 1 line-index, 2 PRBS, 3 zero
- o_busy  out  1  high from start accept until last frame ends
- o_vsync  out  1  vertical sync, polarity per VSYNC_POL
- o_hsync  out  1  horizontal sync, polarity per HSYNC_POL
- o_de  out  1  data enable
- o_data  out  NCH*DW  channel c at bits [c*DW +: DW]
- o_frame_done  out  1  one-cycle pulse on last clock of each frame

Behaviour:
- Reset (asynchronous, active-high): state IDLE, counters 0, o_busy=0, o_de=0, o_data=0, o_frame_done=0. Syncs go to the inactive level: 0 if POL=0, 1 if POL=1. Reset mid-frame aborts immediately; no partial-frame completion.
- FSM states: IDLE, RUN, LAST.
  - IDLE→RUN on i_start. i_nframes and i_mode are latched at acceptance.
  - RUN: h counter 0..HTOT-1 (HTOT = HSW+HBP+HACT+HFP). The v counter 0..VTOT-1 advances when the h counter wraps.
  - At the end of each frame: the frame counter increments and i_mode is re-latched. If the frame counter equals the latched nframes (nonzero), or a stop is pending, go to IDLE.
  - i_stop sets a sticky stop_pending flag, cleared on return to IDLE.
  - LAST: one cycle after the final frame. Outputs are inactive, o_busy=0. Then IDLE.
- Latency: the first hsync-active cycle is the clock after the cycle where i_start is sampled. All outputs are registered.
- Horizontal regions by h count: [0,HSW) sync, then BP, ACT, FP. Vertical regions are analogous by line.
- o_vsync is active for every clock of the VSW lines.
- o_hsync is active for h in [0,HSW) on every line, including vsync lines.
- o_de = vertical ACT AND horizontal ACT.
- o_data is forced to 0 whenever o_de=0.
- With x = active pixel index 0..HACT-1 and y = active line 0..VACT-1, every channel carries:
  - mode 0: x truncated to DW
  - mode 1: y truncated to DW
  - mode 3: 0
- i_start while o_busy is ignored. i_mode changes take effect only at frame boundaries.
- Simultaneous i_start and i_stop in IDLE: start accepted, one frame sent, then stop.

Optional Feature:
- Macro VTG_PRBS_EN.
- Defined: mode 2 drives each channel from its own 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1).
  - Seeds 16'hACE1 + c.
  - The LFSR advances only on o_de cycles; the low DW bits are output.
  - Reseeded at reset only, so the sequence continues across frames.
- Undefined: mode 2 behaves as mode 3 (zeros) and no LFSR logic is built.

Decomposition:
- Package vtg_pkg: the FSM state enum, the region enum (SW/BP/ACT/FP), the mode enum, and the LFSR polynomial/seed constants.
- One sub-module: vtg_pattern. It takes x, y, de and mode and produces the registered o_data, including the LFSRs.
- The counters and FSM stay in the top.

Test Plan:
1. Defaults, i_nframes=1, mode 0:
   - o_busy high 105 cycles (HTOT=15, VTOT=7).
   - o_hsync high at offsets 0,15,...,90; o_vsync high offsets 0..14.
   - First o_de at offset 33; line data 0..9.
   - Four DE bursts of 10; o_frame_done at offset 104.
2. i_nframes=10: exactly 1050 busy cycles, 400 DE cycles, 10 o_frame_done pulses, outputs idle afterwards.
3. VSYNC_POL=1, HSYNC_POL=1: idle levels both 1; sync pulses go low at the same offsets as scenario 1.
4. i_nframes=0, mode 1: assert i_stop during frame 3 line 4. Frame 3 completes (ACT-line data 0,1,2,3), then o_busy drops; exactly 3 o_frame_done pulses.
5. Assert rst at offset 37 of frame 1: o_de, o_data and o_busy go 0 and syncs go inactive the same cycle, without a clock edge. A restart then begins a fresh frame at offset 0.
6. With VTG_PRBS_EN, mode 2, 2 frames: channel 0 first pixel = 16'hACE1 truncated to 10 bits (0x0E1). 80 DE values match a reference LFSR model, and frame 2 continues the sequence. Without the macro: all zeros. i_start pulses during busy are ignored.

Source files
------------

// File: rtl/vtg_pkg.sv
// vtg_pkg: shared types and constants for video_timing_gen.
//   vtg_state_e  : sequencing FSM states
//   vtg_region_e : sync / back porch / active / front porch
//   vtg_mode_e   : test-pattern selection
//   LFSR_SEED / LFSR_TAPS / lfsr_next : PRBS generator (x^16+x^14+x^13+x^11+1)
//   region_of    : maps a counter value to its raster region
package vtg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } vtg_state_e;

  typedef enum logic [1:0] {
    RG_SW  = 2'd0,
    RG_BP  = 2'd1,
    RG_ACT = 2'd2,
    RG_FP  = 2'd3
  } vtg_region_e;

  typedef enum logic [1:0] {
    MODE_RAMP = 2'd0,
    MODE_LINE = 2'd1,
    MODE_PRBS = 2'd2,
    MODE_ZERO = 2'd3
  } vtg_mode_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form: feedback taps on state bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = ^(s & LFSR_TAPS);
    return {fb, s[15:1]};
  endfunction

  function automatic vtg_region_e region_of(input int unsigned cnt,
                                            input int unsigned sw,
                                            input int unsigned bp,
                                            input int unsigned act);
    if (cnt < sw)                return RG_SW;
    else if (cnt < sw + bp)      return RG_BP;
    else if (cnt < sw + bp + act) return RG_ACT;
    else                         return RG_FP;
  endfunction

endpackage

// File: rtl/vtg_pattern.sv
// vtg_pattern: registered test-pattern generator for video_timing_gen.
// Ports:
//   clk, rst    : pixel clock, asynchronous active-high reset
//   de_i        : data enable for the coming output cycle
//   x_i, y_i    : active pixel / active line index for the coming cycle
//   mode_i      : pattern select (vtg_mode_e)
//   data_o      : NCH channels of DW bits, channel c at [c*DW +: DW]; 0 when de_i=0
// Optional: VTG_PRBS_EN builds one 16-bit LFSR per channel for mode 2;
// without it mode 2 outputs zeros.
module vtg_pattern
  import vtg_pkg::*;
#(
  parameter int DW  = 10,
  parameter int NCH = 3,
  parameter int XW  = 4,
  parameter int YW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_i,
  input  logic [XW-1:0]     x_i,
  input  logic [YW-1:0]     y_i,
  input  logic [1:0]        mode_i,
  output logic [NCH*DW-1:0] data_o
);

`ifdef VTG_PRBS_EN
  logic [15:0] lfsr_q [NCH];

  // Reseeded only by reset so the sequence runs on across frames; it steps
  // only when a PRBS pixel is actually emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) lfsr_q[c] <= LFSR_SEED + 16'(c);
    end else if (de_i && (vtg_mode_e'(mode_i) == MODE_PRBS)) begin
      for (int c = 0; c < NCH; c++) lfsr_q[c] <= lfsr_next(lfsr_q[c]);
    end
  end
`endif

  logic [NCH*DW-1:0] data_d;

  always_comb begin
    data_d = '0;
    if (de_i) begin
      for (int c = 0; c < NCH; c++) begin
        case (vtg_mode_e'(mode_i))
          MODE_RAMP: data_d[c*DW +: DW] = DW'(x_i);
          MODE_LINE: data_d[c*DW +: DW] = DW'(y_i);
`ifdef VTG_PRBS_EN
          MODE_PRBS: data_d[c*DW +: DW] = DW'(lfsr_q[c]);
`endif
          default:   data_d[c*DW +: DW] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_o <= '0;
    else     data_o <= data_d;
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing and test-pattern source.
// Ports:
//   clk, rst      : pixel clock, asynchronous active-high reset
//   i_start       : start request, accepted only when idle
//   i_nframes     : frames to send, 0 = continuous (latched at start)
//   i_stop        : stop at end of current frame (sticky until idle)
//   i_mode        : pattern, re-latched at each frame boundary
//   o_busy        : high from start acceptance until last frame ends
//   o_vsync/o_hsync : syncs, polarity from VSYNC_POL/HSYNC_POL
//   o_de, o_data  : data enable and NCH*DW pixel data (0 outside DE)
//   o_frame_done  : pulse on the last clock of each frame
// Optional: define VTG_PRBS_EN to enable the PRBS pattern (mode 2).
//
// state   | meaning
// IDLE    | waiting for i_start, outputs inactive
// RUN     | scanning h/v counters, one frame after another
// LAST    | one inactive cycle after the final frame, then IDLE
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int DW        = 10,
  parameter int NCH       = 3,
  parameter int VSYNC_POL = 0,
  parameter int HSYNC_POL = 0,
  parameter int VSW       = 1,
  parameter int VBP       = 1,
  parameter int VACT      = 4,
  parameter int VFP       = 1,
  parameter int HSW       = 1,
  parameter int HBP       = 2,
  parameter int HACT      = 10,
  parameter int HFP       = 2,
  parameter int FCW       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [FCW-1:0]    i_nframes,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  output logic              o_busy,
  output logic              o_vsync,
  output logic              o_hsync,
  output logic              o_de,
  output logic [NCH*DW-1:0] o_data,
  output logic              o_frame_done
);

  localparam int HTOT = HSW + HBP + HACT + HFP;
  localparam int VTOT = VSW + VBP + VACT + VFP;
  localparam int HW   = (HTOT > 1) ? $clog2(HTOT) : 1;
  localparam int VW   = (VTOT > 1) ? $clog2(VTOT) : 1;
  localparam logic HS_INV = (HSYNC_POL != 0);
  localparam logic VS_INV = (VSYNC_POL != 0);

  vtg_state_e      state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d, fcnt_inc;
  logic [FCW-1:0]  nfr_q, nfr_d;
  logic [1:0]      mode_q, mode_d;
  logic            stop_q, stop_d;
  logic            eof;

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    fcnt_d   = fcnt_q;
    nfr_d    = nfr_q;
    mode_d   = mode_q;
    stop_d   = stop_q;
    eof      = (h_q == HW'(HTOT - 1)) && (v_q == VW'(VTOT - 1));
    fcnt_inc = fcnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          h_d     = '0;
          v_d     = '0;
          fcnt_d  = '0;
          nfr_d   = i_nframes;
          mode_d  = i_mode;
          stop_d  = i_stop;
        end
      end
      ST_RUN: begin
        stop_d = stop_q | i_stop;
        if (h_q == HW'(HTOT - 1)) begin
          h_d = '0;
          v_d = (v_q == VW'(VTOT - 1)) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
        if (eof) begin
          fcnt_d = fcnt_inc;
          mode_d = i_mode;
          // A stop raised on the very last clock still ends this frame.
          if (((nfr_q != '0) && (fcnt_inc == nfr_q)) || stop_d)
            state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        state_d = ST_IDLE;
        stop_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next-state counters and registered, so the
  // first sync cycle appears right after the start is sampled.
  logic        run_d, hs_act, vs_act, de_d, fd_d;
  logic [HW-1:0] x_d;
  logic [VW-1:0] y_d;

  always_comb begin
    run_d  = (state_d == ST_RUN);
    hs_act = run_d && (region_of(32'(h_d), HSW, HBP, HACT) == RG_SW);
    vs_act = run_d && (region_of(32'(v_d), VSW, VBP, VACT) == RG_SW);
    de_d   = run_d && (region_of(32'(h_d), HSW, HBP, HACT) == RG_ACT)
                   && (region_of(32'(v_d), VSW, VBP, VACT) == RG_ACT);
    fd_d   = run_d && (h_d == HW'(HTOT - 1)) && (v_d == VW'(VTOT - 1));
    x_d    = h_d - HW'(HSW + HBP);
    y_d    = v_d - VW'(VSW + VBP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      h_q          <= '0;
      v_q          <= '0;
      fcnt_q       <= '0;
      nfr_q        <= '0;
      mode_q       <= '0;
      stop_q       <= 1'b0;
      o_busy       <= 1'b0;
      o_hsync      <= HS_INV;
      o_vsync      <= VS_INV;
      o_de         <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      fcnt_q       <= fcnt_d;
      nfr_q        <= nfr_d;
      mode_q       <= mode_d;
      stop_q       <= stop_d;
      o_busy       <= run_d;
      o_hsync      <= hs_act ^ HS_INV;
      o_vsync      <= vs_act ^ VS_INV;
      o_de         <= de_d;
      o_frame_done <= fd_d;
    end
  end

  vtg_pattern #(
    .DW (DW),
    .NCH(NCH),
    .XW (HW),
    .YW (VW)
  ) u_pattern (
    .clk   (clk),
    .rst   (rst),
    .de_i  (de_d),
    .x_i   (x_d),
    .y_i   (y_d),
    .mode_i(mode_d),
    .data_o(o_data)
  );

endmodule
